// File: rtl/sequence_player.sv
// sequence_player: replays steps 0..round_i of the colour sequence on four one-hot LEDs,
// each step lit for ON_CYCLES clocks and then blanked for OFF_CYCLES clocks.
module sequence_player #(
    parameter int N          = 4,
    parameter int ON_CYCLES  = 3,
    parameter int OFF_CYCLES = 2,
    parameter int TW         = 16
) (
    input  logic         clk_i,
    input  logic         r_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] round_i,
    output logic [N-1:0] seq_addr_o,
    input  logic [1:0]   seq_data_i,
    output logic [3:0]   led_o,
    output logic         busy_o,
    output logic         done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, ON, OFF, DONE} state_t;
    state_t        state;
    logic [TW-1:0] timer;
    logic [N-1:0]  last;
    assign busy_o = state inside {FETCH, ON, OFF};
    assign done_o = state == DONE;
    always_ff @(posedge clk_i or negedge r_i) begin
        if (!r_i) begin
            state      <= IDLE;
            seq_addr_o <= '0;
            led_o      <= '0;
            timer      <= '0;
            last       <= '0;
        end else if (abort_i) begin
            state      <= IDLE;
            seq_addr_o <= '0;
            led_o      <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    led_o <= '0;
                    if (start_i) begin
                        last       <= round_i;
                        seq_addr_o <= '0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    led_o <= 4'b0001 << seq_data_i;
                    timer <= TW'(ON_CYCLES - 1);
                    state <= ON;
                end
                ON: begin
                    if (timer == '0) begin
                        led_o <= '0;
                        timer <= TW'(OFF_CYCLES - 1);
                        state <= OFF;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                OFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (seq_addr_o == last) begin
                        state <= DONE;
                    end else begin
                        seq_addr_o <= seq_addr_o + 1'b1;
                        state      <= FETCH;
                    end
                end
                DONE: begin
                    led_o <= '0;
                    state <= IDLE;
                end
                default: begin
                    led_o <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed vector table, hand-written reset/abort sequences and
// randomized playbacks checked against a cycle-index model of the playback schedule.
module tb_sequence_player;
    localparam int N   = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = 1 + ON + OFF;

    logic         clk = 0;
    logic         r = 0;
    logic         start = 0;
    logic         abort = 0;
    logic [N-1:0] round = '0;
    logic [N-1:0] seq_addr;
    logic [1:0]   seq_data;
    logic [3:0]   led;
    logic         busy;
    logic         done;
    logic [1:0]   mem [16];
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic         start;
        logic         abort;
        logic [N-1:0] round;
        logic [3:0]   led;
        logic         busy;
        logic         done;
        logic [N-1:0] addr;
    } vec_t;
    vec_t tv[$];

    sequence_player #(.N(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .TW(16)) dut (
        .clk_i(clk), .r_i(r), .start_i(start), .abort_i(abort), .round_i(round),
        .seq_addr_o(seq_addr), .seq_data_i(seq_data), .led_o(led), .busy_o(busy), .done_o(done)
    );

    assign seq_data = mem[seq_addr];
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got led=%b busy=%b done=%b addr=%0d, expected led=%b busy=%b done=%b addr=%0d",
                     name, got[10:7], got[6], got[5], got[3:0], want[10:7], want[6], want[5], want[3:0]);
        end
    endtask

    function automatic logic [10:0] outs();
        return {led, busy, done, 1'b0, seq_addr};
    endfunction

    function automatic logic [10:0] pack(input logic [3:0] l, input logic b, input logic d, input logic [N-1:0] a);
        return {l, b, d, 1'b0, a};
    endfunction

    function automatic void add(input logic s, input logic ab, input int rd,
                                input logic [3:0] l, input logic b, input logic d, input int a);
        vec_t v;
        v.start = s; v.abort = ab; v.round = N'(rd);
        v.led = l; v.busy = b; v.done = d; v.addr = N'(a);
        tv.push_back(v);
    endfunction

    // Expected outputs k edges after the start edge: each step occupies P cycles
    // (one fetch, ON lit, OFF blank), then one DONE cycle, then idle holding last.
    function automatic logic [10:0] model(input int k, input int last);
        int step = k / P;
        int ph = k % P;
        logic [3:0] one = 4'b0001;
        if (step <= last)
            return pack((ph >= 1 && ph <= ON) ? one << mem[step] : 4'b0000, 1'b1, 1'b0, N'(step));
        if (k == (last + 1) * P)
            return pack(4'b0000, 1'b0, 1'b1, N'(last));
        return pack(4'b0000, 1'b0, 1'b0, N'(last));
    endfunction

    task automatic play(input int last, input bit noise);
        int fin = (last + 1) * P;
        @(negedge clk);
        round = N'(last);
        start = 1;
        for (int k = 0; k <= fin + 1; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("play L=%0d k=%0d", last, k), outs(), model(k, last));
            @(negedge clk);
            start = (noise && k <= fin) ? 1'($urandom) : 1'b0;
            round = noise ? N'($urandom) : N'(last);
        end
        start = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hold", outs(), '0);
        @(negedge clk);
        r = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle after reset", outs(), '0);
        end

        mem[0] = 2; mem[1] = 3;
        // single step, with start pulses while busy and in DONE ignored
        add(1, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(1, 0, 3, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0100, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 0);
        add(1, 0, 0, 4'b0000, 0, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        // abort beats start in IDLE
        add(1, 1, 1, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        // two steps, aborted during the off-gap of step 1
        add(1, 0, 1, 4'b0000, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b0100, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 0, 4'b0000, 1, 0, 0);
        add(0, 0, 0, 4'b0000, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 4'b1000, 1, 0, 1);
        add(0, 0, 0, 4'b0000, 1, 0, 1);
        add(0, 1, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        add(0, 0, 0, 4'b0000, 0, 0, 0);
        foreach (tv[i]) begin
            @(negedge clk);
            start = tv[i].start;
            abort = tv[i].abort;
            round = tv[i].round;
            @(posedge clk);
            #1;
            chk($sformatf("vector %0d", i), outs(), pack(tv[i].led, tv[i].busy, tv[i].done, tv[i].addr));
        end
        @(negedge clk);
        start = 0; abort = 0;

        // asynchronous reset while a step is lit
        @(negedge clk);
        round = 2; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit before reset", {led != 4'b0000, busy}, {1'b1, 1'b1});
        #2;
        r = 0;
        #1;
        chk("async reset mid-ON", outs(), '0);
        @(negedge clk);
        r = 1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("idle after mid-ON reset", outs(), '0);
        end

        mem[0] = 1; mem[1] = 3; mem[2] = 0;
        play(2, 0);
        for (int i = 0; i < 16; i++) mem[i] = 2'((i * 3 + 1) % 4);
        play(15, 0);
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 2'($urandom);
            play($urandom_range(0, 15), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
